// File: rtl/tile_writer.sv
// tile_writer: buffers (row, col, index) tile updates in a small FIFO and
// drives the registered 32-bit tile-map control word, at most one word per clock.
// Optional full-screen clear engine: define TILE_WRITER_CLEAR_EN to include it.
// Without it the FSM stays in IDLE, clear_req/clear_index are ignored and
// clear_busy is tied low.
module tile_writer #(
    parameter int FIFO_DEPTH = 8,
    parameter int ROWS       = 30,
    parameter int COLS       = 40
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [5:0]                    req_row,
    input  logic [5:0]                    req_col,
    input  logic [7:0]                    req_index,
    input  logic                          clear_req,
    input  logic [7:0]                    clear_index,
    output logic                          clear_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          oob_err,
    output logic [31:0]                   control
);
    localparam int              AW       = $clog2(FIFO_DEPTH);
    localparam int              CW       = AW + 1;
    localparam logic [5:0]      ROW_LAST = 6'(ROWS - 1);
    localparam logic [5:0]      COL_LAST = 6'(COLS - 1);
    localparam logic [CW-1:0]   DEPTH    = CW'(FIFO_DEPTH);

    typedef enum logic {IDLE, SWEEP} state_t;

    // FIFO entries are stored pre-packed as {col, row, index}
    logic [19:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [31:0]   control_reg;
    logic [31:0]   control_next;
    logic          oob_reg;
    state_t        state_reg;
    state_t        state_next;
    logic          in_range;
    logic          push_fire;
    logic          push;
    logic          pop;

`ifdef TILE_WRITER_CLEAR_EN
    logic [5:0]    sw_row_reg;
    logic [5:0]    sw_row_next;
    logic [5:0]    sw_col_reg;
    logic [5:0]    sw_col_next;
    logic [7:0]    fill_reg;
    logic [7:0]    fill_next;
`else
    logic          unused_clear;
    assign unused_clear = clear_req ^ (^clear_index);
`endif

    // Out-of-range requests are consumed (handshake completes) but never stored
    assign in_range  = (req_row <= ROW_LAST) && (req_col <= COL_LAST);
    assign push_fire = req_valid && req_ready;
    assign push      = push_fire && in_range;

    assign req_ready  = (count_reg < DEPTH);
    assign fifo_count = count_reg;
    assign oob_err    = oob_reg;
    assign control    = control_reg;
`ifdef TILE_WRITER_CLEAR_EN
    assign clear_busy = (state_reg == SWEEP);
`else
    assign clear_busy = 1'b0;
`endif

    // Request storage; left without reset so it can map onto RAM
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {req_col, req_row, req_index};
        end
    end

    // Next-state, pop decision and next control word
    always_comb begin
        state_next   = state_reg;
        control_next = control_reg;
        pop          = 1'b0;
`ifdef TILE_WRITER_CLEAR_EN
        sw_row_next  = sw_row_reg;
        sw_col_next  = sw_col_reg;
        fill_next    = fill_reg;
`endif
        case (state_reg)
            IDLE: begin
`ifdef TILE_WRITER_CLEAR_EN
                // A clear wins over a pending pop, so queued work lands on top of the fill
                if (clear_req) begin
                    state_next  = SWEEP;
                    fill_next   = clear_index;
                    sw_row_next = '0;
                    sw_col_next = '0;
                end else if (count_reg != '0) begin
                    pop          = 1'b1;
                    control_next = {12'h000, mem[rd_ptr_reg]};
                end
`else
                if (count_reg != '0) begin
                    pop          = 1'b1;
                    control_next = {12'h000, mem[rd_ptr_reg]};
                end
`endif
            end
`ifdef TILE_WRITER_CLEAR_EN
            SWEEP: begin
                // Raster order: column fastest; explicit end compares, no power-of-two wrap
                control_next = {12'h000, sw_col_reg, sw_row_reg, fill_reg};
                if (sw_col_reg == COL_LAST) begin
                    sw_col_next = '0;
                    if (sw_row_reg == ROW_LAST) begin
                        state_next = IDLE;
                    end else begin
                        sw_row_next = sw_row_reg + 6'd1;
                    end
                end else begin
                    sw_col_next = sw_col_reg + 6'd1;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    // State, FIFO bookkeeping and output registers; reset discards all pending work
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            control_reg <= 32'h0;
            oob_reg     <= 1'b0;
`ifdef TILE_WRITER_CLEAR_EN
            sw_row_reg  <= '0;
            sw_col_reg  <= '0;
            fill_reg    <= '0;
`endif
        end else begin
            state_reg   <= state_next;
            control_reg <= control_next;
            oob_reg     <= push_fire && !in_range;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
`ifdef TILE_WRITER_CLEAR_EN
            sw_row_reg  <= sw_row_next;
            sw_col_reg  <= sw_col_next;
            fill_reg    <= fill_next;
`endif
        end
    end

endmodule

// File: tb/tb_tile_writer.sv
// tb_tile_writer: randomized + directed bench for tile_writer with a queue-based
// scoreboard. The expected output stream is the list of words still owed by the
// DUT: accepted in-range requests append, an accepted clear prepends the whole
// raster fill. A monitor pops one word each time control changes value.
module tb_tile_writer;
    localparam int ROWS      = 30;
    localparam int COLS      = 40;
    localparam int DEPTH     = 8;
    localparam int SWEEP_LEN = ROWS * COLS;

    logic        clk         = 1'b0;
    logic        reset_n     = 1'b1;
    logic        req_valid   = 1'b0;
    logic        req_ready;
    logic [5:0]  req_row     = '0;
    logic [5:0]  req_col     = '0;
    logic [7:0]  req_index   = '0;
    logic        clear_req   = 1'b0;
    logic [7:0]  clear_index = '0;
    logic        clear_busy;
    logic [3:0]  fifo_count;
    logic        oob_err;
    logic [31:0] control;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_prev = 32'h0;
    int          sweep_left = 0;
    int          cyc = 0;
    int          last_evt_cyc = -10;
    int          run_len = 0;

    tile_writer #(.FIFO_DEPTH(DEPTH), .ROWS(ROWS), .COLS(COLS)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_row(req_row), .req_col(req_col), .req_index(req_index),
        .clear_req(clear_req), .clear_index(clear_index), .clear_busy(clear_busy),
        .fifo_count(fifo_count), .oob_err(oob_err), .control(control)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic logic [31:0] tile_word(input logic [5:0] c, input logic [5:0] r, input logic [7:0] idx);
        return {12'h000, c, r, idx};
    endfunction

    // Word the DUT will have on control just before the next owed word appears
    function automatic logic [31:0] last_word();
        if (exp_q.size() != 0) return exp_q[exp_q.size() - 1];
        return mon_prev;
    endfunction

    // Random in-range request whose word differs from its predecessor, so each
    // emitted word is visible as a change on control
    task automatic gen_req(output logic [5:0] r, output logic [5:0] c, output logic [7:0] x);
        do begin
            r = 6'($urandom_range(ROWS - 1));
            c = 6'($urandom_range(COLS - 1));
            x = 8'($urandom);
        end while (tile_word(c, r, x) == last_word());
    endtask

    function automatic logic [7:0] pick_fill();
        logic [7:0] f;
        do begin
            f = 8'($urandom);
        end while (tile_word(6'd0, 6'd0, f) == mon_prev ||
                   (exp_q.size() != 0 && exp_q[0] == tile_word(6'(COLS - 1), 6'(ROWS - 1), f)));
        return f;
    endfunction

    // One clock of stimulus; called at negedge+1, returns at the next negedge+1
    task automatic step(input bit v, input logic [5:0] r, input logic [5:0] c, input logic [7:0] x,
                        input bit clr, input logic [7:0] cidx);
        bit acc;
        bit inr;
        bit clr_ok;
        int mcnt;
        mcnt = exp_q.size() - sweep_left;
        acc  = v && (mcnt < DEPTH);
        inr  = (int'(r) < ROWS) && (int'(c) < COLS);
`ifdef TILE_WRITER_CLEAR_EN
        clr_ok = clr && (sweep_left == 0);
`else
        clr_ok = 1'b0;
`endif
        req_valid   = v;
        req_row     = r;
        req_col     = c;
        req_index   = x;
        clear_req   = clr;
        clear_index = cidx;
        if (clr_ok) begin
            for (int k = SWEEP_LEN - 1; k >= 0; k--) begin
                exp_q.push_front(tile_word(6'(k % COLS), 6'(k / COLS), cidx));
            end
            $display("[TB] t=%0t clear fill=%02h queued=%0d", $time, cidx, mcnt);
        end
        if (acc && inr) begin
            exp_q.push_back(tile_word(c, r, x));
            $display("[TB] t=%0t push row=%0d col=%0d idx=%02h", $time, r, c, x);
        end else if (acc) begin
            $display("[TB] t=%0t push out-of-range row=%0d col=%0d (discard)", $time, r, c);
        end
        @(posedge clk);
        if (clr_ok) sweep_left = SWEEP_LEN;
        else if (sweep_left > 0) sweep_left--;
        @(negedge clk);
        #1;
        mcnt = exp_q.size() - sweep_left;
        chk("oob_err", 32'(oob_err), 32'(acc && !inr));
        chk("clear_busy", 32'(clear_busy), 32'(sweep_left > 0));
        chk("fifo_count", 32'(fifo_count), 32'(mcnt));
        chk("req_ready", 32'(req_ready), 32'(mcnt < DEPTH));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 6'd0, 6'd0, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic wait_sweep_end();
        for (int i = 0; i < SWEEP_LEN + 100 && clear_busy === 1'b1; i++) idle(1);
        chk("sweep_ended_in_time", 32'(clear_busy), 32'h0);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 2 * SWEEP_LEN + 200 && exp_q.size() != 0; i++) idle(1);
        chk("all_words_emitted", 32'(exp_q.size()), 32'h0);
    endtask

    // Asynchronous reset: outputs must clear without any clock edge
    task automatic do_reset();
        reset_n   = 1'b0;
        req_valid = 1'b0;
        clear_req = 1'b0;
        #1;
        chk("rst_control", control, 32'h0);
        chk("rst_clear_busy", 32'(clear_busy), 32'h0);
        chk("rst_fifo_count", 32'(fifo_count), 32'h0);
        chk("rst_oob_err", 32'(oob_err), 32'h0);
        chk("rst_req_ready", 32'(req_ready), 32'h1);
        exp_q.delete();
        sweep_left = 0;
        $display("[TB] t=%0t reset", $time);
        @(negedge clk);
        @(posedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        #1;
    endtask

    // Monitor: every change of control is one emitted word
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                mon_prev = control;
            end else if (control !== mon_prev) begin
                if (cyc == last_evt_cyc + 1) run_len++;
                else run_len = 1;
                last_evt_cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_word: got 0x%08h, expected no new word (held 0x%08h)", control, mon_prev);
                end else begin
                    chk("control_word", control, exp_q.pop_front());
                end
                mon_prev = control;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]  r;
        logic [5:0]  c;
        logic [7:0]  x;
        logic [7:0]  f;
        logic [31:0] w;
        logic [31:0] held;
        logic [3:0]  cnt_before;
        int          busy_cnt;
        bit          v;
        bit          clr;

        #1;
        do_reset();

        // Basic write and one-cycle latency
        step(1'b1, 6'd2, 6'd5, 8'h1A, 1'b0, 8'h00);
        idle(1);
        chk("first_write", control, 32'h0001_421A);
        idle(3);
        chk("first_write_held", control, 32'h0001_421A);

        // Out-of-range requests are swallowed; boundary tile is accepted
        held = control;
        cnt_before = fifo_count;
        step(1'b1, 6'd30, 6'd2, 8'h77, 1'b0, 8'h00);
        chk("oob_row_control", control, held);
        chk("oob_row_count", 32'(fifo_count), 32'(cnt_before));
        step(1'b1, 6'd3, 6'd40, 8'h78, 1'b0, 8'h00);
        chk("oob_col_control", control, held);
        idle(1);
        step(1'b1, 6'd29, 6'd39, 8'hC3, 1'b0, 8'h00);
        idle(1);
        chk("corner_tile", control, tile_word(6'd39, 6'd29, 8'hC3));

`ifdef TILE_WRITER_CLEAR_EN
        // Full clear: busy exactly ROWS*COLS cycles, first and last words
        step(1'b0, 6'd0, 6'd0, 8'h00, 1'b1, 8'h05);
        busy_cnt = int'(clear_busy);
        idle(1);
        busy_cnt += int'(clear_busy);
        chk("sweep_first_word", control, tile_word(6'd0, 6'd0, 8'h05));
        for (int i = 0; i < SWEEP_LEN + 100 && clear_busy === 1'b1; i++) begin
            idle(1);
            busy_cnt += int'(clear_busy);
        end
        chk("sweep_busy_cycles", 32'(busy_cnt), 32'(SWEEP_LEN));
        chk("sweep_last_word", control, 32'h0009_DD05);

        // Fill the FIFO during a sweep; drain follows the sweep with no gap
        f = pick_fill();
        step(1'b0, 6'd0, 6'd0, 8'h00, 1'b1, f);
        for (int i = 0; i < DEPTH; i++) begin
            gen_req(r, c, x);
            step(1'b1, r, c, x, 1'b0, 8'h00);
        end
        chk("full_count", 32'(fifo_count), 32'(DEPTH));
        chk("full_not_ready", 32'(req_ready), 32'h0);
        for (int i = 0; i < 3; i++) begin
            gen_req(r, c, x);
            step(1'b1, r, c, x, 1'b0, 8'h00);
        end
        wait_sweep_end();
        wait_drain();
        chk("sweep_then_drain_contiguous", 32'(run_len), 32'(SWEEP_LEN + DEPTH));

        // Clear with a queued entry: sweep first; a second clear mid-sweep is ignored
        gen_req(r, c, x);
        w = tile_word(c, r, x);
        step(1'b1, r, c, x, 1'b0, 8'h00);
        f = pick_fill();
        step(1'b0, 6'd0, 6'd0, 8'h00, 1'b1, f);
        idle(100);
        step(1'b0, 6'd0, 6'd0, 8'h00, 1'b1, ~f);
        wait_sweep_end();
        idle(1);
        chk("queued_after_sweep", control, w);

        // Reset mid-sweep with three queued entries
        f = pick_fill();
        step(1'b0, 6'd0, 6'd0, 8'h00, 1'b1, f);
        for (int i = 0; i < 3; i++) begin
            gen_req(r, c, x);
            step(1'b1, r, c, x, 1'b0, 8'h00);
        end
        idle(10);
        do_reset();
        idle(20);
        chk("no_stale_after_reset", control, 32'h0);
`else
        // Clear engine absent: clear_req must be ignored
        held = control;
        step(1'b0, 6'd0, 6'd0, 8'h00, 1'b1, 8'h05);
        idle(5);
        chk("clear_ignored", control, held);

        // Reset while a word is still queued
        gen_req(r, c, x);
        step(1'b1, r, c, x, 1'b0, 8'h00);
        do_reset();
        idle(20);
        chk("no_stale_after_reset", control, 32'h0);
`endif

        // Randomized traffic, including out-of-range requests and occasional clears
        for (int i = 0; i < 800; i++) begin
            clr = 1'b0;
`ifdef TILE_WRITER_CLEAR_EN
            if ($urandom_range(399) == 0 && sweep_left == 0) clr = 1'b1;
`endif
            v = !clr && ($urandom_range(99) < 60);
            if ($urandom_range(9) == 0) begin
                r = 6'($urandom_range(63));
                c = 6'($urandom_range(63));
                x = 8'($urandom);
                if (int'(r) < ROWS && int'(c) < COLS) r = 6'(ROWS + $urandom_range(63 - ROWS));
            end else begin
                gen_req(r, c, x);
            end
            f = clr ? pick_fill() : 8'h00;
            step(v, r, c, x, clr, f);
        end
        wait_sweep_end();
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
